keypad_scan: RTL and testbench

Input-side counterpart of the board's 4-digit seven-segment driver. It scans a 4x4 hex keypad by driving one active-low row at a time, reads the active-low columns, and debounces presses. Each accepted key is shifted as a hex nibble into a 16-bit value register, so the CPU and display see the digits as they are typed.

---
 rtl/keypad_pkg.sv | 37 +++
 rtl/sync_2ff.sv | 27 ++
 rtl/keypad_scan.sv | 165 ++++++++++++++++
 tb/tb_keypad_scan.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner: FSM states, scan-result
// encoding, row drive patterns and the snapshot decoder.
package keypad_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_CAND, ST_HELD, ST_REL} state_e;

   typedef enum logic [1:0] {SCAN_NONE, SCAN_SINGLE, SCAN_MULTI} scan_res_e;

   typedef struct packed {
      scan_res_e  res;
      logic [3:0] code;
   } scan_t;

   localparam logic [3:0] ROW_IDLE = 4'b1111;

   // Active-low row drive: exactly one row low.
   function automatic logic [3:0] row_pattern(input logic [1:0] idx);
      return ROW_IDLE & ~(4'b0001 << idx);
   endfunction

   // Snapshot bit {row,col} is low when pressed, so its index is the key code.
   function automatic scan_t decode_scan(input logic [15:0] snap);
      scan_t       r;
      int unsigned n;
      n      = 0;
      r.code = 4'h0;
      for (int i = 0; i < 16; i++) begin
         if (!snap[i]) begin
            n++;
            r.code = 4'(i);
         end
      end
      r.res = (n == 0) ? SCAN_NONE : ((n == 1) ? SCAN_SINGLE : SCAN_MULTI);
      return r;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous board inputs, with a settable reset value.
module sync_2ff #(
   parameter int unsigned       WIDTH   = 4,
   parameter logic [WIDTH-1:0]  RST_VAL = '1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 hex keypad scanner: row-at-a-time scan, per-scan debounce FSM, and a
// 16-bit shift register collecting accepted digits.
module keypad_scan
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV       = 100000,
   parameter int unsigned DEBOUNCE_SCANS = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic [3:0]  row,
   input  logic [3:0]  col,
   input  logic        clear,
   output logic [15:0] value,
   output logic [3:0]  key_code,
   output logic        key_valid
);

   localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [3:0]       col_s;
   logic [DIV_W-1:0] div_q, div_d;
   logic [1:0]       row_idx_q, row_idx_d;
   logic [3:0]       row_q, row_d;
   logic [15:0]      snap_q, snap_d;
   logic             done_q, done_d;
   state_e           state_q, state_d;
   logic [3:0]       cand_q, cand_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic [15:0]      value_q, value_d;
   logic [3:0]       key_code_q, key_code_d;
   logic             key_valid_q, key_valid_d;
   logic             capture;
   logic             accept;
   scan_t            scan;

   sync_2ff #(.WIDTH(4), .RST_VAL(ROW_IDLE)) u_col_sync (
      .clk (clk),
      .rst (rst),
      .d_i (col),
      .q_o (col_s)
   );

   // Row scan: capture the synced columns of the driven row, then advance.
   always_comb begin
      capture   = (div_q == DIV_LAST);
      div_d     = capture ? '0 : div_q + DIV_W'(1);
      row_idx_d = capture ? row_idx_q + 2'd1 : row_idx_q;
      row_d     = row_pattern(row_idx_d);
      snap_d    = snap_q;
      if (capture) begin
         snap_d[{row_idx_q, 2'b00} +: 4] = col_s;
      end
      done_d    = capture && (row_idx_q == 2'd3);
   end

   assign scan    = decode_scan(snap_q);
   assign cnt_inc = cnt_q + CNT_ONE;

   // Debounce FSM, stepped one cycle after each completed scan.
   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      if (done_q) begin
         unique case (state_q)
            ST_IDLE: begin
               if (scan.res == SCAN_SINGLE) begin
                  cand_d = scan.code;
                  cnt_d  = CNT_ONE;
                  if (CNT_DONE == CNT_ONE) begin
                     accept  = 1'b1;
                     state_d = ST_HELD;
                  end else begin
                     state_d = ST_CAND;
                  end
               end
            end
            ST_CAND: begin
               if (scan.res == SCAN_SINGLE && scan.code == cand_q) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc >= CNT_DONE) begin
                     accept  = 1'b1;
                     state_d = ST_HELD;
                  end
               end else if (scan.res == SCAN_SINGLE) begin
                  cand_d = scan.code;
                  cnt_d  = CNT_ONE;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_HELD: begin
               if (scan.res == SCAN_NONE) begin
                  cnt_d   = CNT_ONE;
                  state_d = (CNT_DONE == CNT_ONE) ? ST_IDLE : ST_REL;
               end
            end
            ST_REL: begin
               if (scan.res == SCAN_NONE) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc >= CNT_DONE) begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  state_d = ST_HELD;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Clear overrides the shift but not the pulse or code.
   always_comb begin
      key_valid_d = accept;
      key_code_d  = accept ? cand_d : key_code_q;
      if (clear) begin
         value_d = '0;
      end else if (accept) begin
         value_d = {value_q[11:0], cand_d};
      end else begin
         value_d = value_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q       <= '0;
         row_idx_q   <= 2'd0;
         row_q       <= row_pattern(2'd0);
         snap_q      <= {4{ROW_IDLE}};
         done_q      <= 1'b0;
         state_q     <= ST_IDLE;
         cand_q      <= 4'h0;
         cnt_q       <= '0;
         value_q     <= 16'h0000;
         key_code_q  <= 4'h0;
         key_valid_q <= 1'b0;
      end else begin
         div_q       <= div_d;
         row_idx_q   <= row_idx_d;
         row_q       <= row_d;
         snap_q      <= snap_d;
         done_q      <= done_d;
         state_q     <= state_d;
         cand_q      <= cand_d;
         cnt_q       <= cnt_d;
         value_q     <= value_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
      end
   end

   assign row       = row_q;
   assign value     = value_q;
   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: keypad model, vector table of press/release patterns,
// and a scoreboard of expected accepted keys.
module tb_keypad_scan;

   logic        clk;
   logic        rst;
   logic [3:0]  row;
   logic [3:0]  col;
   logic        clear;
   logic [15:0] value;
   logic [3:0]  key_code;
   logic        key_valid;

   logic [15:0] keys;
   int          cyc;
   int          pulses;
   int          n_checks;
   int          n_pass;

   typedef struct {
      logic [3:0]  code;
      logic [15:0] value;
   } exp_t;
   exp_t sb[$];
   exp_t mon_e;

   typedef struct {
      logic [15:0] keys;
      int          hold;
      int          gap;
      logic        exp_pulse;
      logic [3:0]  exp_code;
      logic [15:0] exp_value;
   } vec_t;
   vec_t vecs[11];

   keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .row       (row),
      .col       (col),
      .clear     (clear),
      .value     (value),
      .key_code  (key_code),
      .key_valid (key_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Keypad: a pressed key shorts its column low while its row is driven low.
   always_comb begin
      col = 4'b1111;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (keys[r*4 + c] && !row[r]) col[c] = 1'b0;
         end
      end
   end

   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else n_pass++;
   endtask

   // Scoreboard: every pulse must match the oldest expected key.
   always @(negedge clk) begin
      if (!rst && key_valid) begin
         pulses++;
         if (sb.size() == 0) begin
            check("unexpected_pulse", 32'(key_code), 32'hFFFF_FFFF);
         end else begin
            mon_e = sb.pop_front();
            check("sb_code", 32'(key_code), 32'(mon_e.code));
            check("sb_value", 32'(value), 32'(mon_e.value));
         end
      end
   end

   task automatic align_scan();
      int guard = 0;
      @(negedge clk);
      while ((cyc % 16) != 0 && guard < 64) begin
         @(negedge clk);
         guard++;
      end
   endtask

   task automatic press(input logic [15:0] k, input int hold, input int gap);
      align_scan();
      keys = k;
      repeat (hold * 16) @(negedge clk);
      keys = 16'h0000;
      repeat (gap * 16) @(negedge clk);
   endtask

   initial begin
      int   p0;
      int   n;
      logic found;
      logic [3:0] re;

      n_checks = 0;
      n_pass   = 0;
      pulses   = 0;
      keys     = 16'h0000;
      clear    = 1'b0;
      rst      = 1'b1;

      vecs[0]  = '{16'h0040, 5, 3, 1'b1, 4'h6, 16'h0006};
      vecs[1]  = '{16'h0002, 3, 3, 1'b1, 4'h1, 16'h0061};
      vecs[2]  = '{16'h0004, 3, 3, 1'b1, 4'h2, 16'h0612};
      vecs[3]  = '{16'h0008, 3, 3, 1'b1, 4'h3, 16'h6123};
      vecs[4]  = '{16'h0010, 3, 3, 1'b1, 4'h4, 16'h1234};
      vecs[5]  = '{16'h0020, 3, 3, 1'b1, 4'h5, 16'h2345};
      vecs[6]  = '{16'h0080, 1, 1, 1'b0, 4'h0, 16'h2345};
      vecs[7]  = '{16'h0080, 1, 1, 1'b0, 4'h0, 16'h2345};
      vecs[8]  = '{16'h0080, 1, 3, 1'b0, 4'h0, 16'h2345};
      vecs[9]  = '{16'h0300, 4, 0, 1'b0, 4'h0, 16'h2345};
      vecs[10] = '{16'h0200, 3, 3, 1'b1, 4'h9, 16'h3459};

      // Reset values and row rotation.
      repeat (2) @(negedge clk);
      check("rst_row", 32'(row), 32'(4'b1110));
      check("rst_value", 32'(value), 32'h0);
      check("rst_valid", 32'(key_valid), 32'h0);
      check("rst_code", 32'(key_code), 32'h0);
      rst = 1'b0;
      for (int k = 1; k <= 17; k++) begin
         @(negedge clk);
         re = 4'b1111;
         re[(k / 4) % 4] = 1'b0;
         check($sformatf("row_rot_%0d", k), 32'(row), 32'(re));
      end

      // Table of press/release patterns.
      for (int v = 0; v < 11; v++) begin
         if (vecs[v].exp_pulse) sb.push_back('{vecs[v].exp_code, vecs[v].exp_value});
         p0 = pulses;
         press(vecs[v].keys, vecs[v].hold, vecs[v].gap);
         check($sformatf("vec%0d_pulses", v), 32'(pulses - p0), 32'(vecs[v].exp_pulse));
         check($sformatf("vec%0d_value", v), 32'(value), 32'(vecs[v].exp_value));
      end

      // Clear alone, then A, B, and clear coinciding with the accept of C.
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check("clear_value", 32'(value), 32'h0);
      sb.push_back('{4'hA, 16'h000A});
      press(16'h0400, 2, 3);
      sb.push_back('{4'hB, 16'h00AB});
      press(16'h0800, 2, 3);
      check("pre_clear_value", 32'(value), 32'h00AB);
      sb.push_back('{4'hC, 16'h0000});
      align_scan();
      keys = 16'h1000;
      repeat (32) @(negedge clk);
      keys  = 16'h0000;
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check("clr_acc_valid", 32'(key_valid), 32'h1);
      check("clr_acc_code", 32'(key_code), 32'hC);
      check("clr_acc_value", 32'(value), 32'h0);
      repeat (48) @(negedge clk);

      // Reset while in CAND with the key held: full debounce restarts.
      align_scan();
      keys = 16'h4000;
      repeat (20) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_row", 32'(row), 32'(4'b1110));
      check("midrst_value", 32'(value), 32'h0);
      check("midrst_valid", 32'(key_valid), 32'h0);
      check("midrst_code", 32'(key_code), 32'h0);
      sb.push_back('{4'hE, 16'h000E});
      repeat (3) @(negedge clk);
      rst   = 1'b0;
      n     = 0;
      found = 1'b0;
      while (!found && n < 60) begin
         @(negedge clk);
         n++;
         if (key_valid) found = 1'b1;
      end
      check("midrst_latency", 32'(n), 32'd33);
      keys = 16'h0000;
      repeat (64) @(negedge clk);
      check("sb_drained", 32'(sb.size()), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
